// File: rtl/lab_MS_SV4_pack.sv
`default_nettype none
// ============================================================================
// Module   : lab_MS_SV4_pack
// Purpose  : Shared types for the registered signed ALU and its bench.
//            data_t  - signed 8-bit operand
//            data_y  - signed 16-bit result
//            opc_t   - 3-bit opcode enum (ADD..SRA)
//            INST_t  - packed instruction {opc, op_a, op_b}, 19 bits
// Revision : 1.0 - initial release
// ============================================================================
package lab_MS_SV4_pack;

  typedef logic signed [7:0]  data_t;
  typedef logic signed [15:0] data_y;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    AND = 3'd4,
    OR  = 3'd5,
    XOR = 3'd6,
    SRA = 3'd7
  } opc_t;

  // opc sits in bits [18:16], op_a in [15:8], op_b in [7:0].
  typedef struct packed {
    opc_t  opc;
    data_t op_a;
    data_t op_b;
  } INST_t;

endpackage
`default_nettype wire

// File: rtl/lab_ms_sv4_alu.sv
`default_nettype none
// ============================================================================
// Module   : lab_ms_sv4_alu
// Purpose  : Registered 8-opcode signed ALU. One instruction is sampled on
//            every rising clock edge; its 16-bit signed result appears on
//            ALU_out from that edge on (one cycle of latency, no stall).
// Ports    : clk      in   system clock, rising edge
//            rst_n    in   asynchronous reset, active-low (clears ALU_out)
//            INST     in   INST_t {opc, op_a, op_b}
//            ALU_out  out  registered signed 16-bit result
// Revision : 1.0 - initial release
// ============================================================================
module lab_ms_sv4_alu
  import lab_MS_SV4_pack::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  INST_t INST,
  output data_y ALU_out
);

  data_y w_a_ext;
  data_y w_b_ext;
  data_t w_narrow;
  data_y w_result;
  data_y r_alu_out;

  always_comb begin
    // Arithmetic ops work on 16-bit sign-extended operands so that none of
    // them can overflow; -128 / -1 = +128 is representable at this width.
    w_a_ext  = {{8{INST.op_a[7]}}, INST.op_a};
    w_b_ext  = {{8{INST.op_b[7]}}, INST.op_b};
    w_narrow = '0;
    w_result = '0;

    case (INST.opc)
      ADD: w_result = w_a_ext + w_b_ext;
      SUB: w_result = w_a_ext - w_b_ext;
      MUL: w_result = w_a_ext * w_b_ext;
      DIV: begin
        // Divide by zero is defined to yield 0; '/' truncates toward zero.
        if (INST.op_b == '0) begin
          w_result = '0;
        end else begin
          w_result = w_a_ext / w_b_ext;
        end
      end
      AND: begin
        w_narrow = INST.op_a & INST.op_b;
        w_result = {{8{w_narrow[7]}}, w_narrow};
      end
      OR: begin
        w_narrow = INST.op_a | INST.op_b;
        w_result = {{8{w_narrow[7]}}, w_narrow};
      end
      XOR: begin
        w_narrow = INST.op_a ^ INST.op_b;
        w_result = {{8{w_narrow[7]}}, w_narrow};
      end
      SRA: begin
        // Only the low three bits of op_b form the shift amount.
        w_narrow = INST.op_a >>> INST.op_b[2:0];
        w_result = {{8{w_narrow[7]}}, w_narrow};
      end
      // Reached only by X/unknown opcodes in four-state simulation.
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out <= '0;
    end else begin
      r_alu_out <= w_result;
    end
  end

  assign ALU_out = r_alu_out;

endmodule
`default_nettype wire

// File: tb/tb_lab_ms_sv4_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab_ms_sv4_alu
// Purpose  : Self-checking bench for lab_ms_sv4_alu. Expected results come
//            from an integer-arithmetic model of the opcode rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab_ms_sv4_alu;
  import lab_MS_SV4_pack::*;

  logic  clk;
  logic  rst_n;
  INST_t INST;
  data_y ALU_out;

  int checks;
  int failures;

  lab_ms_sv4_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INST    (INST),
    .ALU_out (ALU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the signed operand values.
  function automatic int model(input opc_t op, input int a, input int b);
    int r;
    case (op)
      ADD: r = a + b;
      SUB: r = a - b;
      MUL: r = a * b;
      DIV: r = (b == 0) ? 0 : a / b;
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      SRA: r = a >>> (b & 7);
      default: r = 0;
    endcase
    return r;
  endfunction

  // Drive an instruction away from the active edge, then sample after it.
  task automatic apply(input opc_t op, input int a, input int b);
    @(negedge clk);
    INST.opc  = op;
    INST.op_a = data_t'(a);
    INST.op_b = data_t'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int got;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(opc_t'($urandom_range(0, 7)), int'($urandom_range(1, 127)),
            int'($urandom_range(1, 127)));
      got = int'(ALU_out);
      checks++;
      if (got !== 0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%0d expected=0", i, got);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(ADD, 100, 20);
    got = int'(ALU_out);
    checks++;
    if (got !== 120) begin
      failures++;
      $display("FAIL reset_release got=%0d expected=120", got);
    end
    // Asynchronous assertion between edges.
    #2;
    rst_n = 1'b0;
    #1;
    got = int'(ALU_out);
    checks++;
    if (got !== 0) begin
      failures++;
      $display("FAIL reset_async got=%0d expected=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int exp_vals[8] = '{5, 15, -50, -2, 10, -5, -15, 1};
    int got;
    for (int i = 0; i < 8; i++) begin
      apply(opc_t'(i), 10, -5);
      got = int'(ALU_out);
      checks++;
      if (got !== exp_vals[i]) begin
        failures++;
        $display("FAIL sweep opc=%0d got=%0d expected=%0d", i, got, exp_vals[i]);
      end
    end
  endtask

  task automatic test_extremes();
    opc_t ops[8] = '{MUL, ADD, SUB, DIV, DIV, DIV, SRA, SRA};
    int   as[8]  = '{-128, 127, -128, -128, 55, 7, -128, -128};
    int   bs[8]  = '{-128, 127, 127, -1, 0, -2, 7, 8};
    int   exps[8] = '{16384, 254, -255, 128, 0, -3, -1, -128};
    int   got;
    for (int i = 0; i < 8; i++) begin
      apply(ops[i], as[i], bs[i]);
      got = int'(ALU_out);
      checks++;
      if (got !== exps[i]) begin
        failures++;
        $display("FAIL extreme idx=%0d opc=%0d a=%0d b=%0d got=%0d expected=%0d",
                 i, ops[i], as[i], bs[i], got, exps[i]);
      end
    end
  endtask

  task automatic test_random();
    int a, b, got, e;
    opc_t op;
    for (int i = 0; i < 300; i++) begin
      op = opc_t'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255)) - 128;
      b  = int'($urandom_range(0, 255)) - 128;
      if (($urandom_range(0, 15) == 0)) b = 0;
      apply(op, a, b);
      got = int'(ALU_out);
      e   = model(op, a, b);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL random opc=%0d a=%0d b=%0d got=%0d expected=%0d",
                 op, a, b, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b, got, e;
    opc_t op;
    for (int i = 0; i < 8; i++) begin
      op = opc_t'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255)) - 128;
      b  = int'($urandom_range(0, 255)) - 128;
      apply(op, a, b);
      got = int'(ALU_out);
      e   = model(op, a, b);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b idx=%0d opc=%0d a=%0d b=%0d got=%0d expected=%0d",
                 i, op, a, b, got, e);
      end
      if (i == 3) begin
        // Mid-stream reset: result must clear and stay clear while held.
        #2;
        rst_n = 1'b0;
        #1;
        got = int'(ALU_out);
        checks++;
        if (got !== 0) begin
          failures++;
          $display("FAIL b2b_reset got=%0d expected=0", got);
        end
        apply(ADD, 1, 2);
        got = int'(ALU_out);
        checks++;
        if (got !== 0) begin
          failures++;
          $display("FAIL b2b_reset_hold got=%0d expected=0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    INST     = '0;
    test_reset();
    test_sweep();
    test_extremes();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
